// File: rtl/mfp_rojo_upd_handshake.sv
// Rojobot update capture: edge-detects update strobes, queues BotInfo snapshots
// in a small FIFO and pops one entry per rising edge of the software acknowledge.
module mfp_rojo_upd_handshake #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int OVF_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             BOT_UPDT_RAW,
  input  logic [31:0]      BOT_INFO_RAW,
  input  logic             PORT_INTACK,
  output logic [31:0]      PORT_BOTINFO,
  output logic             PORT_BOTUPDT,
  output logic [AW:0]      FIFO_LEVEL,
  output logic             OVF_FLAG,
  output logic [OVF_W-1:0] OVF_COUNT
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Handshake: a rising edge on BOT_UPDT_RAW offers one word (BOT_INFO_RAW) and a
  // rising edge on PORT_INTACK consumes the head; held levels never repeat an event.
  logic             upd_d, ack_d;
  logic             push, pop, do_push, do_pop;
  logic             is_empty, is_full;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      botinfo_q;
  logic             botupdt_q;
  logic             ovf_flag;
  logic [OVF_W-1:0] ovf_count;

  assign push     = BOT_UPDT_RAW & ~upd_d;
  assign pop      = PORT_INTACK & ~ack_d;
  assign is_empty = (level == '0);
  assign is_full  = (level == FULL_LVL);
  assign do_pop   = pop & ~is_empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push  = push & (~is_full | do_pop);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      upd_d     <= BOT_UPDT_RAW;
      ack_d     <= PORT_INTACK;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf_flag  <= 1'b0;
      ovf_count <= '0;
      botinfo_q <= '0;
      botupdt_q <= 1'b0;
    end else begin
      upd_d <= BOT_UPDT_RAW;
      ack_d <= PORT_INTACK;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
      if (push && !do_push) begin
        ovf_flag <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + OVF_W'(1);
      end
      // Presentation stage: reflects the queue as it stood before this edge.
      botupdt_q <= ~is_empty;
      botinfo_q <= is_empty ? 32'h0 : mem[rd_ptr];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && do_push) mem[wr_ptr] <= BOT_INFO_RAW;
  end

  assign PORT_BOTINFO = botinfo_q;
  assign PORT_BOTUPDT = botupdt_q;
  assign FIFO_LEVEL   = level;
  assign OVF_FLAG     = ovf_flag;
  assign OVF_COUNT    = ovf_count;

endmodule

// File: tb/tb_mfp_rojo_upd_handshake.sv
// Bench for mfp_rojo_upd_handshake: queue-based reference model feeding a scoreboard
// that is drained by a negedge monitor, plus directed checks at key scenario points.
module tb_mfp_rojo_upd_handshake;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int OVF_W = 8;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             BOT_UPDT_RAW = 1'b0;
  logic [31:0]      BOT_INFO_RAW = '0;
  logic             PORT_INTACK = 1'b0;
  logic [31:0]      PORT_BOTINFO;
  logic             PORT_BOTUPDT;
  logic [AW:0]      FIFO_LEVEL;
  logic             OVF_FLAG;
  logic [OVF_W-1:0] OVF_COUNT;

  mfp_rojo_upd_handshake #(.DEPTH(DEPTH), .AW(AW), .OVF_W(OVF_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .BOT_UPDT_RAW(BOT_UPDT_RAW), .BOT_INFO_RAW(BOT_INFO_RAW),
    .PORT_INTACK(PORT_INTACK), .PORT_BOTINFO(PORT_BOTINFO), .PORT_BOTUPDT(PORT_BOTUPDT),
    .FIFO_LEVEL(FIFO_LEVEL), .OVF_FLAG(OVF_FLAG), .OVF_COUNT(OVF_COUNT)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // expected vector: {botinfo[44:13], botupdt[12], level[11:9], ovf_flag[8], ovf_count[7:0]}
  logic [44:0] exp_q[$];

  // reference model state
  logic [31:0] mq[$];
  bit          m_upd_d = 0;
  bit          m_ack_d = 0;
  bit          m_ovf   = 0;
  int          m_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs for one edge, advance the model, queue expected outputs
  task automatic step(input bit rst, input bit upd, input bit ack, input logic [31:0] info);
    bit          ev_push, ev_pop, had;
    logic [31:0] head;
    HRESET       = rst;
    BOT_UPDT_RAW = upd;
    PORT_INTACK  = ack;
    BOT_INFO_RAW = info;
    @(posedge HCLK);
    had  = (mq.size() != 0);
    head = had ? mq[0] : 32'h0;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_cnt = 0;
      had   = 0;
      head  = 32'h0;
    end else begin
      ev_push = upd && !m_upd_d;
      ev_pop  = ack && !m_ack_d;
      if (ev_pop && mq.size() > 0) void'(mq.pop_front());
      if (ev_push) begin
        if (mq.size() < DEPTH) mq.push_back(info);
        else begin
          m_ovf = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    m_upd_d = upd;
    m_ack_d = ack;
    exp_q.push_back({head, had, 3'(mq.size()), m_ovf, 8'(m_cnt)});
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, BOT_UPDT_RAW, PORT_INTACK, BOT_INFO_RAW);
  endtask

  task automatic pulse_upd(input logic [31:0] v);
    step(0, 1, PORT_INTACK, v);
    step(0, 0, PORT_INTACK, $urandom);
  endtask

  task automatic pulse_ack();
    step(0, BOT_UPDT_RAW, 1, BOT_INFO_RAW);
    step(0, BOT_UPDT_RAW, 0, BOT_INFO_RAW);
  endtask

  // scoreboard monitor
  always @(negedge HCLK) begin
    logic [44:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("botinfo", PORT_BOTINFO, e[44:13]);
      chk("botupdt", 32'(PORT_BOTUPDT), 32'(e[12]));
      chk("level", 32'(FIFO_LEVEL), 32'(e[11:9]));
      chk("ovf_flag", 32'(OVF_FLAG), 32'(e[8]));
      chk("ovf_count", 32'(OVF_COUNT), 32'(e[7:0]));
    end
  end

  initial begin
    @(negedge HCLK);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_level", 32'(FIFO_LEVEL), 0);
    chk("reset_botupdt", 32'(PORT_BOTUPDT), 0);

    // single pulse: visible two edges after the rise
    step(0, 1, 0, 32'h0012_3456);
    step(0, 0, 0, 32'h0);
    chk("pulse_botinfo", PORT_BOTINFO, 32'h0012_3456);
    chk("pulse_botupdt", 32'(PORT_BOTUPDT), 1);
    chk("pulse_level", 32'(FIFO_LEVEL), 1);
    pulse_ack();
    idle(1);

    // held update level yields a single entry
    for (int i = 0; i < 10; i++) step(0, 1, 0, 32'hB000_0000 + 32'(i));
    step(0, 0, 0, 0);
    idle(1);
    chk("held_level", 32'(FIFO_LEVEL), 1);
    chk("held_botinfo", PORT_BOTINFO, 32'hB000_0000);
    pulse_ack();
    idle(1);
    chk("held_drain_botupdt", 32'(PORT_BOTUPDT), 0);
    chk("held_drain_botinfo", PORT_BOTINFO, 0);

    // six rises into DEPTH=4
    for (int v = 1; v <= 6; v++) pulse_upd(32'(v));
    chk("ovf_level", 32'(FIFO_LEVEL), 4);
    chk("ovf_flag6", 32'(OVF_FLAG), 1);
    chk("ovf_count6", 32'(OVF_COUNT), 2);
    for (int v = 1; v <= 4; v++) begin
      chk("drain_order", PORT_BOTINFO, 32'(v));
      pulse_ack();
    end
    idle(1);
    chk("drain_empty", 32'(FIFO_LEVEL), 0);

    // full FIFO with simultaneous push and pop
    for (int v = 0; v < 4; v++) pulse_upd(32'hA + 32'(v));
    step(0, 1, 1, 32'hE);
    step(0, 0, 0, 32'h0);
    chk("simul_count", 32'(OVF_COUNT), 2);
    chk("simul_level", 32'(FIFO_LEVEL), 4);
    chk("simul_head", PORT_BOTINFO, 32'hB);
    for (int i = 0; i < 4; i++) pulse_ack();
    idle(1);

    // ack on empty, held ack, then update presented until a fresh ack rise
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
    chk("empty_ack_level", 32'(FIFO_LEVEL), 0);
    pulse_upd(32'h5555_AAAA);
    idle(2);
    chk("held_ack_keeps", PORT_BOTINFO, 32'h5555_AAAA);
    step(0, 0, 0, 0);
    pulse_ack();
    idle(1);
    chk("fresh_ack_pops", 32'(PORT_BOTUPDT), 0);

    // reset with entries queued and update held high
    for (int v = 0; v < 3; v++) pulse_upd(32'hC0 + 32'(v));
    step(0, 1, 0, 32'hDEAD);
    step(1, 1, 0, 32'hDEAD);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hBEEF);
    chk("rst_level", 32'(FIFO_LEVEL), 0);
    chk("rst_botupdt", 32'(PORT_BOTUPDT), 0);
    chk("rst_ovf", 32'(OVF_FLAG), 0);
    step(0, 0, 0, 0);
    pulse_upd(32'h1234);
    idle(1);
    chk("rst_repush", PORT_BOTINFO, 32'h1234);

    // saturating overflow counter
    step(1, 0, 0, 0);
    for (int i = 0; i < 4 + 300; i++) pulse_upd($urandom);
    chk("sat_count", 32'(OVF_COUNT), 32'hFF);
    chk("sat_level", 32'(FIFO_LEVEL), 4);

    // randomized traffic
    step(1, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom);

    step(0, 0, 0, 0);
    repeat (2) @(negedge HCLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
